jt49_env_ctl: RTL and testbench

Register-side driver for the JT49 envelope generator. Decodes CPU writes to the three envelope registers (fine period R11, coarse period R12, shape R13) and provides registered read-back. Owns the 16-bit envelope period divider, producing the `step`, `null_period`, `restart` and `ctrl[3:0]` signals the envelope generator consumes. Sits between the JT49 bus decoder and the envelope generator, in the divided `clk`/`cen` domain.

---
 rtl/jt49_pkg.sv | 35 +++
 rtl/jt49_env_ctl_if.sv | 25 ++
 rtl/jt49_env_div.sv | 57 +++++
 rtl/jt49_env_ctl.sv | 80 ++++++++
 tb/tb_jt49_env_ctl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jt49_pkg.sv
// Shared constants for the JT49 envelope register block: register indices,
// shape bit positions and the address decode helper.
package jt49_pkg;

    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned SHAPE_W  = 4;

    localparam logic [ADDR_W-1:0] ENV_FINE   = 4'd11;
    localparam logic [ADDR_W-1:0] ENV_COARSE = 4'd12;
    localparam logic [ADDR_W-1:0] ENV_SHAPE  = 4'd13;

    localparam int unsigned CONT = 3;
    localparam int unsigned ATT  = 2;
    localparam int unsigned ALT  = 1;
    localparam int unsigned HOLD = 0;

    typedef enum logic [1:0] {
        REG_FINE   = 2'd0,
        REG_COARSE = 2'd1,
        REG_SHAPE  = 2'd2,
        REG_NONE   = 2'd3
    } env_reg_e;

    function automatic env_reg_e env_decode(input logic [ADDR_W-1:0] addr);
        env_reg_e sel;
        sel = REG_NONE;
        if (addr == ENV_FINE)   sel = REG_FINE;
        if (addr == ENV_COARSE) sel = REG_COARSE;
        if (addr == ENV_SHAPE)  sel = REG_SHAPE;
        return sel;
    endfunction

endpackage

// File: rtl/jt49_env_ctl_if.sv
// CPU bus and envelope-generator control signals of the envelope register block.
interface jt49_env_ctl_if;
    import jt49_pkg::*;

    logic                 cs_n;
    logic                 wr_n;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    din;
    logic [DATA_W-1:0]    dout;
    logic [SHAPE_W-1:0]   ctrl;
    logic                 restart;
    logic                 step;
    logic                 null_period;

    modport master (
        output cs_n, wr_n, addr, din,
        input  dout, ctrl, restart, step, null_period
    );

    modport slave (
        input  cs_n, wr_n, addr, din,
        output dout, ctrl, restart, step, null_period
    );

endinterface

// File: rtl/jt49_env_div.sv
// Envelope period divider: 2^PRE_W prescaler feeding a 16-bit period counter,
// emitting a registered one-cen-wide step at each period wrap.
module jt49_env_div
    import jt49_pkg::*;
#(
    parameter int unsigned PRE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clr,
    output logic                step
);

    logic [PRE_W-1:0]    pre, pre_nx;
    logic [PERIOD_W-1:0] cnt, cnt_nx;
    logic                step_nx;

    // Period 0 is special-cased so period-1 never underflows into a wrap.
    always_comb begin
        pre_nx  = pre;
        cnt_nx  = cnt;
        step_nx = step;
        if (clr) begin
            pre_nx  = '0;
            cnt_nx  = '0;
            step_nx = 1'b0;
        end else if (cen) begin
            pre_nx  = PRE_W'(pre + 1'b1);
            step_nx = 1'b0;
            if (&pre) begin
                if (period == '0) begin
                    cnt_nx = '0;
                end else if (cnt >= PERIOD_W'(period - 16'd1)) begin
                    cnt_nx  = '0;
                    step_nx = 1'b1;
                end else begin
                    cnt_nx = PERIOD_W'(cnt + 16'd1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            pre  <= pre_nx;
            cnt  <= cnt_nx;
            step <= step_nx;
        end
    end

endmodule

// File: rtl/jt49_env_ctl.sv
// Envelope register block: R11/R12/R13 write decode with single-write strobe
// detection, registered read-back, restart pulse and the period divider.
module jt49_env_ctl
    import jt49_pkg::*;
#(
    parameter int unsigned PRE_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    jt49_env_ctl_if.slave  bus
);

    logic [DATA_W-1:0]  r11, r12;
    logic [SHAPE_W-1:0] r13;
    logic [DATA_W-1:0]  dout_q;
    logic               restart_q;
    logic               wr_n_q;
    logic               we;
    logic               shape_we;
    logic               step;
    env_reg_e           sel;

    // Falling edge of wr_n under chip select: one write per strobe.
    assign we       = !bus.cs_n && !bus.wr_n && wr_n_q;
    assign sel      = env_decode(bus.addr);
    assign shape_we = we && (sel == REG_SHAPE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r11       <= '0;
            r12       <= '0;
            r13       <= '0;
            dout_q    <= '0;
            restart_q <= 1'b0;
            wr_n_q    <= 1'b1;
        end else begin
            wr_n_q    <= bus.wr_n;
            restart_q <= shape_we;
            if (we) begin
                case (sel)
                    REG_FINE:   r11 <= bus.din;
                    REG_COARSE: r12 <= bus.din;
                    REG_SHAPE:  r13 <= bus.din[SHAPE_W-1:0];
                    default:    ;
                endcase
            end
            case (sel)
                REG_FINE:   dout_q <= r11;
                REG_COARSE: dout_q <= r12;
                REG_SHAPE:  dout_q <= {4'h0, r13};
                default:    dout_q <= 8'hFF;
            endcase
        end
    end

    always_comb begin
        bus.ctrl       = '0;
        bus.ctrl[CONT] = r13[CONT];
        bus.ctrl[ATT]  = r13[ATT];
        bus.ctrl[ALT]  = r13[ALT];
        bus.ctrl[HOLD] = r13[HOLD];
    end

    assign bus.dout        = dout_q;
    assign bus.restart     = restart_q;
    assign bus.null_period = ({r12, r11} == 16'd0);
    assign bus.step        = step;

    // Shape write restarts the divider in the same cycle the registers update.
    jt49_env_div #(.PRE_W(PRE_W)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .period ({r12, r11}),
        .clr    (shape_we),
        .step   (step)
    );

endmodule

// File: tb/tb_jt49_env_ctl.sv
// Directed self-checking bench for jt49_env_ctl with a read-back and step-time
// scoreboard.
module tb_jt49_env_ctl;
    import jt49_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic cen;

    always #5 clk = ~clk;

    jt49_env_ctl_if bus();

    jt49_env_ctl #(.PRE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  rd_q[$];
    int          step_q[$];
    int          t_we;
    logic        rs_seen;
    logic [3:0]  ctrl_seen;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.addr = a;
        bus.din  = d;
        tick;
        t_we      = cyc;
        rs_seen   = bus.restart;
        ctrl_seen = bus.ctrl;
        bus.wr_n  = 1'b1;
        bus.cs_n  = 1'b1;
        tick;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        bus.addr = a;
        rd_q.push_back(exp);
        tick;
        check($sformatf("rd_addr%0d", a), 32'(bus.dout), 32'(rd_q.pop_front()));
    endtask

    task automatic wait_step(input int max, output int t);
        t = -1;
        for (int i = 0; i < max; i++) begin
            tick;
            if (bus.step) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic count_steps(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            tick;
            if (bus.step) hits++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t_prev, t0, n;

        rst_n    = 1'b0;
        cen      = 1'b1;
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.addr = 4'd0;
        bus.din  = 8'd0;
        repeat (3) tick;
        check("rst_restart", 32'(bus.restart), 32'd0);
        check("rst_step",    32'(bus.step), 32'd0);
        check("rst_ctrl",    32'(bus.ctrl), 32'd0);
        check("rst_null",    32'(bus.null_period), 32'd1);
        check("rst_dout",    32'(bus.dout), 32'd0);
        rst_n = 1'b1;
        tick;

        rd(4'd11, 8'h00);
        rd(4'd12, 8'h00);
        rd(4'd13, 8'h00);
        rd(4'd5,  8'hFF);

        count_steps(1000, n);
        check("null_no_step", 32'(n), 32'd0);

        // Period 3 -> 48 clk interval
        wr(4'd11, 8'd3);
        check("null_clear", 32'(bus.null_period), 32'd0);
        wr(4'd12, 8'd0);

        // Shape write with wr_n held low for 10 clocks
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.addr = 4'd13;
        bus.din  = 8'h0E;
        tick;
        t_we = cyc;
        check("hold_restart", 32'(bus.restart), 32'd1);
        check("hold_ctrl",    32'(bus.ctrl), 32'hE);
        n = 0;
        repeat (9) begin
            tick;
            if (bus.restart) n++;
        end
        check("restart_single", 32'(n), 32'd0);
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        step_q.push_back(t_we + 48);
        wait_step(100, t);
        check("step_first", 32'(t), 32'(step_q.pop_front()));
        tick;
        check("step_width", 32'(bus.step), 32'd0);
        t_prev = t;
        wait_step(100, t);
        check("step_int1", 32'(t - t_prev), 32'd48);
        t_prev = t;
        wait_step(100, t);
        check("step_int2", 32'(t - t_prev), 32'd48);

        rd(4'd11, 8'h03);
        rd(4'd12, 8'h00);
        rd(4'd13, 8'h0E);
        rd(4'd0,  8'hFF);
        rd(4'd15, 8'hFF);

        // Period 100, shrink to 10 once cnt reaches 60
        wr(4'd11, 8'd100);
        wr(4'd13, 8'h0E);
        t0 = t_we;
        n = 0;
        while (cyc < t0 + 964) begin
            tick;
            if (bus.step) n++;
        end
        check("p100_no_step", 32'(n), 32'd0);
        wr(4'd11, 8'd10);
        step_q.push_back(t0 + 976);
        wait_step(200, t);
        check("shrink_step", 32'(t), 32'(step_q.pop_front()));
        t_prev = t;
        wait_step(300, t);
        check("shrink_int", 32'(t - t_prev), 32'd160);

        // Shape write on the exact wrap cycle
        wr(4'd11, 8'd3);
        wr(4'd13, 8'h0E);
        t0 = t_we;
        n = 0;
        while (cyc < t0 + 47) begin
            tick;
            if (bus.step) n++;
        end
        check("coll_pre_step", 32'(n), 32'd0);
        wr(4'd13, 8'h05);
        check("coll_we_cycle", 32'(t_we), 32'(t0 + 48));
        check("coll_restart",  32'(rs_seen), 32'd1);
        check("coll_ctrl",     32'(ctrl_seen), 32'h5);
        tests++;
        step_q.push_back(t_we + 48);
        wait_step(100, t);
        check("coll_no_step", 32'(t == t0 + 48), 32'd0);
        tests--;
        check("coll_next", 32'(t), 32'(step_q.pop_front()));

        // cen gating with period 1
        wr(4'd11, 8'd1);
        cen = 1'b0;
        wr(4'd13, 8'h08);
        check("cen_off_restart", 32'(rs_seen), 32'd1);
        count_steps(50, n);
        check("cen_off_no_step", 32'(n), 32'd0);
        cen = 1'b1;
        t0 = cyc;
        wait_step(100, t);
        check("cen_on_step", 32'(t - t0), 32'd16);
        t_prev = t;
        wait_step(100, t);
        check("p1_int", 32'(t - t_prev), 32'd16);

        // Reset mid-count while a restart pulse is high
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.addr = 4'd13;
        bus.din  = 8'h03;
        tick;
        check("pre_rst_restart", 32'(bus.restart), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_restart", 32'(bus.restart), 32'd0);
        check("arst_ctrl",    32'(bus.ctrl), 32'd0);
        check("arst_null",    32'(bus.null_period), 32'd1);
        check("arst_step",    32'(bus.step), 32'd0);
        check("arst_dout",    32'(bus.dout), 32'd0);
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            tick;
            if (bus.restart) n++;
        end
        check("post_rst_restart", 32'(n), 32'd0);
        rd(4'd11, 8'h00);
        rd(4'd13, 8'h00);
        count_steps(200, n);
        check("post_rst_no_step", 32'(n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
